// File: rtl/argmax.sv
// Streaming arg-max over one frame of signed class scores; emits a one-hot
// winner per well-formed frame and pulses err_o when a frame has the wrong length.
module argmax #(
  parameter int NUM_CLASSES = 3,
  parameter int I_BW        = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [I_BW-1:0]        data_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic [NUM_CLASSES-1:0] data_o,
  output logic                   valid_o,
  output logic                   last_o,
  input  logic                   ready_i,
  output logic                   err_o
);

  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [0:0] {
    ACCUM   = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t                   state_r, state_s;
  logic [IDX_W-1:0]         idx_r, idx_s;
  logic signed [I_BW-1:0]   best_val_r, best_val_s;
  logic [IDX_W-1:0]         best_idx_r, best_idx_s;
  logic [NUM_CLASSES-1:0]   data_r, data_s;
  logic                     valid_r, valid_s;
  logic                     last_r, last_s;
  logic                     err_r, err_s;

  logic signed [I_BW-1:0]   score_s;
  logic signed [I_BW-1:0]   cand_val_s;
  logic [IDX_W-1:0]         cand_idx_s;
  logic                     accept_s;
  logic                     pop_s;
  logic                     load_out_s;

  function automatic logic [NUM_CLASSES-1:0] onehot(input logic [IDX_W-1:0] sel);
    logic [NUM_CLASSES-1:0] vec;
    vec = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      vec[k] = (sel == IDX_W'(k));
    end
    return vec;
  endfunction

  assign ready_o  = !valid_r | ready_i;
  assign accept_s = valid_i & ready_o;
  assign pop_s    = valid_r & ready_i;
  assign score_s  = $signed(data_i);

  // Candidate winner including the current beat; strict > keeps the lowest index on ties.
  always_comb begin
    cand_val_s = best_val_r;
    cand_idx_s = best_idx_r;
    if (idx_r == '0) begin
      cand_val_s = score_s;
      cand_idx_s = '0;
    end else if (score_s > best_val_r) begin
      cand_val_s = score_s;
      cand_idx_s = idx_r;
    end else begin
      cand_val_s = best_val_r;
      cand_idx_s = best_idx_r;
    end
  end

  // Frame-length FSM and running-best update.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    best_val_s = best_val_r;
    best_idx_s = best_idx_r;
    err_s      = 1'b0;
    load_out_s = 1'b0;
    case (state_r)
      ACCUM: begin
        if (accept_s) begin
          if (last_i) begin
            idx_s = '0;
            if (idx_r == LAST_IDX) begin
              load_out_s = 1'b1;
            end else begin
              err_s = 1'b1;
            end
          end else if (idx_r == LAST_IDX) begin
            err_s   = 1'b1;
            idx_s   = '0;
            state_s = DISCARD;
          end else begin
            best_val_s = cand_val_s;
            best_idx_s = cand_idx_s;
            idx_s      = idx_r + IDX_W'(1);
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DISCARD: begin
        if (accept_s && last_i) begin
          state_s = ACCUM;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = ACCUM;
        idx_s   = '0;
      end
    endcase
  end

  // Output holding register: a completing frame wins over a pop in the same cycle.
  always_comb begin
    data_s  = data_r;
    valid_s = valid_r;
    last_s  = last_r;
    if (load_out_s) begin
      data_s  = onehot(cand_idx_s);
      valid_s = 1'b1;
      last_s  = 1'b1;
    end else if (pop_s) begin
      valid_s = 1'b0;
      last_s  = 1'b0;
    end else begin
      valid_s = valid_r;
      last_s  = last_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ACCUM;
      idx_r      <= '0;
      best_val_r <= '0;
      best_idx_r <= '0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      best_val_r <= best_val_s;
      best_idx_r <= best_idx_s;
      data_r     <= data_s;
      valid_r    <= valid_s;
      last_r     <= last_s;
      err_r      <= err_s;
    end
  end

  assign data_o  = data_r;
  assign valid_o = valid_r;
  assign last_o  = last_r;
  assign err_o   = err_r;

endmodule
